// File: rtl/timer_bank.sv
// Bank of independent prescaled up-counting timers behind a small register bus.
// Each channel exposes COUNT, PERIOD, CONTROL and STATUS and raises a shared level irq.
module timer_bank #(
    parameter int  CHANNELS = 2,
    parameter int  WIDTH    = 16,
    localparam int ADDR_W   = 2 + ((CHANNELS > 1) ? $clog2(CHANNELS) : 0)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              chipselect,
    input  logic [ADDR_W-1:0] addr,
    input  logic              write_en,
    input  logic [WIDTH-1:0]  write_data,
    input  logic              read_en,
    output logic [WIDTH-1:0]  read_data,
    output logic              irq
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    // Bus: no handshake. An access is one cycle wide and is qualified by chipselect;
    // a write lands on the next edge, a read loads read_data on the next edge with the
    // pre-write register value, and read_data holds between reads.
    logic [IDX_W-1:0] ch_idx;
    logic [1:0]       reg_idx;
    logic             ch_ok;
    logic             wr_ok;
    logic             rd_ok;

    if (CHANNELS > 1) begin : g_multi
        assign ch_idx = addr[ADDR_W-1:2];
    end else begin : g_single
        assign ch_idx = 1'b0;
    end

    assign reg_idx = addr[1:0];
    assign ch_ok   = ({{(32-IDX_W){1'b0}}, ch_idx} < 32'(CHANNELS));
    assign wr_ok   = chipselect && write_en && ch_ok;
    assign rd_ok   = chipselect && read_en && ch_ok;

    logic [WIDTH-1:0] count_q   [CHANNELS];
    logic [WIDTH-1:0] count_d   [CHANNELS];
    logic [WIDTH-1:0] period_q  [CHANNELS];
    logic [WIDTH-1:0] period_d  [CHANNELS];
    logic [3:0]       ps_q      [CHANNELS];
    logic [3:0]       ps_d      [CHANNELS];
    logic [14:0]      pre_q     [CHANNELS];
    logic [14:0]      pre_d     [CHANNELS];
    logic             run_q     [CHANNELS];
    logic             run_d     [CHANNELS];
    logic             reload_q  [CHANNELS];
    logic             reload_d  [CHANNELS];
    logic             irq_en_q  [CHANNELS];
    logic             irq_en_d  [CHANNELS];
    logic             pending_q [CHANNELS];
    logic             pending_d [CHANNELS];

    logic [WIDTH-1:0] read_data_q;
    logic             irq_q;
    logic             irq_any;
    logic [WIDTH-1:0] rd_val;

    always_comb begin : next_state
        logic        wr_ch;
        logic        tick;
        logic        expire;
        logic        start;
        logic [14:0] pre_top;
        wr_ch   = 1'b0;
        tick    = 1'b0;
        expire  = 1'b0;
        start   = 1'b0;
        pre_top = '0;
        irq_any = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            wr_ch   = wr_ok && (ch_idx == IDX_W'(c));
            pre_top = (15'd1 << ps_q[c]) - 15'd1;
            tick    = run_q[c] && (pre_q[c] == pre_top);
            expire  = tick && (count_q[c] >= period_q[c]);

            count_d[c]  = count_q[c];
            period_d[c] = period_q[c];
            ps_d[c]     = ps_q[c];
            run_d[c]    = run_q[c];
            reload_d[c] = reload_q[c];
            irq_en_d[c] = irq_en_q[c];

            if (tick) begin
                if (expire) begin
                    if (reload_q[c]) count_d[c] = '0;
                    else             run_d[c]   = 1'b0;
                end else begin
                    count_d[c] = count_q[c] + WIDTH'(1);
                end
            end

            // Expiry beats a same-cycle write-1-to-clear.
            pending_d[c] = expire ||
                           (pending_q[c] && !(wr_ch && (reg_idx == 2'd3) && write_data[1]));

            if (wr_ch) begin
                case (reg_idx)
                    2'd0: count_d[c]  = write_data;
                    2'd1: period_d[c] = write_data;
                    2'd2: begin
                        run_d[c]    = write_data[0];
                        reload_d[c] = write_data[1];
                        irq_en_d[c] = write_data[2];
                        ps_d[c]     = write_data[7:4];
                    end
                    default: ;
                endcase
            end

            start    = wr_ch && (reg_idx == 2'd2) && write_data[0];
            pre_d[c] = (!run_d[c] || start || tick) ? 15'd0 : pre_q[c] + 15'd1;
            irq_any  = irq_any | (pending_q[c] & irq_en_q[c]);
        end
    end

    always_comb begin : read_mux
        rd_val = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_idx == IDX_W'(c)) begin
                case (reg_idx)
                    2'd0: rd_val = count_q[c];
                    2'd1: rd_val = period_q[c];
                    2'd2: begin
                        rd_val[7:4] = ps_q[c];
                        rd_val[2]   = irq_en_q[c];
                        rd_val[1]   = reload_q[c];
                        rd_val[0]   = run_q[c];
                    end
                    default: begin
                        rd_val[1] = pending_q[c];
                        rd_val[0] = run_q[c];
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                count_q[c]   <= '0;
                period_q[c]  <= '0;
                ps_q[c]      <= '0;
                pre_q[c]     <= '0;
                run_q[c]     <= 1'b0;
                reload_q[c]  <= 1'b0;
                irq_en_q[c]  <= 1'b0;
                pending_q[c] <= 1'b0;
            end
            read_data_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                count_q[c]   <= count_d[c];
                period_q[c]  <= period_d[c];
                ps_q[c]      <= ps_d[c];
                pre_q[c]     <= pre_d[c];
                run_q[c]     <= run_d[c];
                reload_q[c]  <= reload_d[c];
                irq_en_q[c]  <= irq_en_d[c];
                pending_q[c] <= pending_d[c];
            end
            if (rd_ok) read_data_q <= rd_val;
            irq_q <= irq_any;
        end
    end

    assign read_data = read_data_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: directed scenarios plus random bus traffic
// compared against a countdown-based behavioural model of the timers.
module tb_timer_bank;
  localparam int CH = 2;
  localparam int W  = 16;
  localparam int AW = 3;

  logic          clock;
  logic          reset;
  logic          chipselect;
  logic [AW-1:0] addr;
  logic          write_en;
  logic [W-1:0]  write_data;
  logic          read_en;
  logic [W-1:0]  read_data;
  logic          irq;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  // Behavioural model state: m_cd counts clocks left until the next tick.
  logic [W-1:0] m_count[CH];
  logic [W-1:0] m_period[CH];
  logic         m_run[CH];
  logic         m_reload[CH];
  logic         m_irq_en[CH];
  logic         m_pending[CH];
  int           m_ps[CH];
  int           m_cd[CH];
  logic         m_irq;
  logic [W-1:0] m_rd;

  timer_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .chipselect (chipselect),
    .addr       (addr),
    .write_en   (write_en),
    .write_data (write_data),
    .read_en    (read_en),
    .read_data  (read_data),
    .irq        (irq)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference model
  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_count[c]   = '0;
      m_period[c]  = '0;
      m_run[c]     = 1'b0;
      m_reload[c]  = 1'b0;
      m_irq_en[c]  = 1'b0;
      m_pending[c] = 1'b0;
      m_ps[c]      = 0;
      m_cd[c]      = 1;
    end
    m_irq = 1'b0;
    m_rd  = '0;
    exp_q.delete();
  endtask

  function automatic logic [W-1:0] reg_value(input int ch, input int r);
    case (r)
      0:       return m_count[ch];
      1:       return m_period[ch];
      2:       return W'(m_ps[ch] * 16 + (m_irq_en[ch] ? 4 : 0) + (m_reload[ch] ? 2 : 0) + (m_run[ch] ? 1 : 0));
      default: return W'((m_pending[ch] ? 2 : 0) + (m_run[ch] ? 1 : 0));
    endcase
  endfunction

  task automatic model_edge();
    int   ch;
    int   r;
    logic nxt_irq;
    logic expire;
    if (reset) begin
      model_reset();
      return;
    end
    ch = int'(addr[AW-1:2]);
    r  = int'(addr[1:0]);
    nxt_irq = 1'b0;
    for (int c = 0; c < CH; c++)
      if (m_pending[c] && m_irq_en[c]) nxt_irq = 1'b1;
    if (chipselect && read_en) begin
      m_rd = reg_value(ch, r);
      exp_q.push_back(m_rd);
    end
    for (int c = 0; c < CH; c++) begin
      expire = 1'b0;
      if (m_run[c]) begin
        if (m_cd[c] == 1) begin
          m_cd[c] = 1 << m_ps[c];
          if (m_count[c] >= m_period[c]) begin
            expire       = 1'b1;
            m_pending[c] = 1'b1;
            if (m_reload[c]) m_count[c] = '0;
            else             m_run[c]   = 1'b0;
          end else begin
            m_count[c] = m_count[c] + W'(1);
          end
        end else begin
          m_cd[c] = m_cd[c] - 1;
        end
      end
      if (chipselect && write_en && ch == c) begin
        case (r)
          0: m_count[c]  = write_data;
          1: m_period[c] = write_data;
          2: begin
            m_run[c]    = write_data[0];
            m_reload[c] = write_data[1];
            m_irq_en[c] = write_data[2];
            m_ps[c]     = int'(write_data[7:4]);
            if (write_data[0]) m_cd[c] = 1 << m_ps[c];
          end
          default: if (write_data[1] && !expire) m_pending[c] = 1'b0;
        endcase
      end
    end
    m_irq = nxt_irq;
  endtask

  // Driver tasks: inputs change 1 ns after the edge, outputs are sampled there too.
  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_eq("irq", irq, m_irq);
    check_eq("read_hold", read_data, m_rd);
    if (exp_q.size() > 0) check_eq("read_data", read_data, exp_q.pop_front());
    chipselect = 1'b0;
    write_en   = 1'b0;
    read_en    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input int ch, input int r, input int data);
    addr       = AW'(ch * 4 + r);
    write_data = W'(data);
    chipselect = 1'b1;
    write_en   = 1'b1;
    step();
  endtask

  task automatic rd(input int ch, input int r);
    addr       = AW'(ch * 4 + r);
    chipselect = 1'b1;
    read_en    = 1'b1;
    step();
  endtask

  initial begin
    reset      = 1'b1;
    chipselect = 1'b0;
    write_en   = 1'b0;
    read_en    = 1'b0;
    addr       = '0;
    write_data = '0;
    model_reset();
    idle(2);
    check_eq("reset_read_data", read_data, 0);
    check_eq("reset_irq", irq, 0);
    reset = 1'b0;
    idle(2);

    // One-shot on ch0
    wr(0, 1, 3);
    wr(0, 2, 'h5);
    idle(1);
    for (int i = 1; i <= 3; i++) begin
      rd(0, 0);
      check_eq("oneshot_count", read_data, i);
    end
    check_eq("oneshot_irq_lag", irq, 0);
    rd(0, 3);
    check_eq("oneshot_status", read_data, 'h2);
    check_eq("oneshot_irq", irq, 1);
    rd(0, 0);
    check_eq("oneshot_hold", read_data, 3);
    wr(0, 3, 2);
    wr(0, 2, 0);

    // Reload with prescale on ch1
    wr(1, 1, 2);
    wr(1, 2, 'h13);
    for (int i = 0; i < 12; i++) begin
      rd(1, 0);
      check_eq("reload_count", read_data, (i / 2) % 3);
      check_eq("reload_irq", irq, 0);
    end
    rd(1, 3);
    check_eq("reload_status", read_data, 'h3);
    wr(1, 2, 0);
    wr(1, 3, 2);

    // W1C colliding with an expiry, then on a quiet cycle
    wr(0, 1, 0);
    wr(0, 2, 'h7);
    idle(1);
    wr(0, 3, 2);
    rd(0, 3);
    check_eq("w1c_race_status", read_data, 'h3);
    wr(0, 2, 'h4);
    wr(0, 3, 2);
    check_eq("w1c_irq_hold", irq, 1);
    idle(1);
    check_eq("w1c_irq_drop", irq, 0);
    rd(0, 3);
    check_eq("w1c_status", read_data, 0);
    wr(0, 2, 0);

    // Period shrink below COUNT while running, then the top-of-range boundary
    wr(0, 0, 10);
    wr(0, 1, 100);
    wr(0, 2, 'h31);
    wr(0, 1, 4);
    idle(5);
    rd(0, 0);
    check_eq("shrink_count_before", read_data, 10);
    rd(0, 3);
    check_eq("shrink_status_before", read_data, 'h1);
    rd(0, 0);
    check_eq("shrink_count_after", read_data, 10);
    rd(0, 3);
    check_eq("shrink_status_after", read_data, 'h2);
    wr(0, 3, 2);
    wr(0, 0, 'hFFFE);
    wr(0, 1, 'hFFFF);
    wr(0, 2, 'h1);
    idle(2);
    rd(0, 0);
    check_eq("max_count_nowrap", read_data, 'hFFFF);
    rd(0, 3);
    check_eq("max_count_status", read_data, 'h2);
    wr(0, 3, 2);

    // Asynchronous reset while ch0 counts and ch1 holds an interrupt
    wr(1, 1, 0);
    wr(1, 2, 'h5);
    wr(0, 1, 100);
    wr(0, 0, 0);
    wr(0, 2, 'h1);
    idle(4);
    rd(0, 0);
    check_eq("pre_reset_count", read_data, 4);
    check_eq("pre_reset_irq", irq, 1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_reset_read_data", read_data, 0);
    check_eq("async_reset_irq", irq, 0);
    model_reset();
    idle(2);
    reset = 1'b0;
    idle(5);
    rd(0, 0);
    check_eq("post_reset_count", read_data, 0);
    rd(0, 3);
    check_eq("post_reset_status0", read_data, 0);
    rd(1, 3);
    check_eq("post_reset_status1", read_data, 0);
    rd(0, 2);
    check_eq("post_reset_control", read_data, 0);

    // Read latency and read/write collision on ch1 PERIOD
    wr(1, 1, 'h1234);
    rd(1, 0);
    check_eq("latency_prior", read_data, 0);
    addr       = AW'(1 * 4 + 1);
    chipselect = 1'b1;
    read_en    = 1'b1;
    #1;
    check_eq("latency_before_edge", read_data, 0);
    step();
    check_eq("latency_after_edge", read_data, 'h1234);
    addr       = AW'(1 * 4 + 1);
    write_data = W'('hBEEF);
    chipselect = 1'b1;
    write_en   = 1'b1;
    read_en    = 1'b1;
    step();
    check_eq("collision_old_value", read_data, 'h1234);
    rd(1, 1);
    check_eq("collision_new_value", read_data, 'hBEEF);

    // Random traffic against the model
    repeat (400) begin
      int ch;
      int r;
      logic [W-1:0] d;
      ch = int'($urandom_range(0, CH - 1));
      r  = int'($urandom_range(0, 3));
      case (r)
        0, 1:    d = W'($urandom_range(0, 6));
        2:       d = W'(($urandom_range(0, 2) << 4) | $urandom_range(0, 15) | ($urandom_range(0, 1) << 12));
        default: d = W'($urandom_range(0, 3));
      endcase
      addr       = AW'(ch * 4 + r);
      write_data = d;
      chipselect = ($urandom_range(0, 7) != 0);
      write_en   = ($urandom_range(0, 2) == 0);
      read_en    = ($urandom_range(0, 1) == 1);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
